// File: rtl/fp4_pkg.sv
// Shared FP4 (E2M1) types and the tag carried alongside each multiply.
package fp4_pkg;
  typedef logic [3:0] fp4_t;

  // E2M1 field positions
  localparam int FP4_SIGN_BIT = 3;
  localparam int FP4_EXP_MSB  = 2;
  localparam int FP4_EXP_LSB  = 1;
  localparam int FP4_MAN_BIT  = 0;

  // Tag id is sized for the largest supported requester count (8)
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } mul_tag_t;

  localparam int MUL_LAT_DEF = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches req_i starting at ptr_i, wrapping modulo
// NUM_REQ, and grants the first asserted request.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               gnt_any_o
);
  // First requester at or after the pointer wins
  always_comb begin
    int k;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    k         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr_i) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!gnt_any_o && req_i[ID_W'(k)]) begin
        gnt_any_o         = 1'b1;
        gnt_o[ID_W'(k)]   = 1'b1;
        gnt_idx_o         = ID_W'(k);
      end
    end
  end
endmodule

// File: rtl/fp4_mul_arbiter.sv
// Shares one FP4 multiplier between NUM_REQ requesters. Grants round-robin,
// tags each issue with its requester id through the multiplier latency and
// steers the returning result back to that requester.
module fp4_mul_arbiter
  import fp4_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*4-1:0] i_req_a,
  input  logic [NUM_REQ*4-1:0] i_req_b,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_mul_valid,
  output fp4_t                 o_mul_a,
  output fp4_t                 o_mul_b,
  input  fp4_t                 i_mul_result,
  input  logic                 i_mul_valid,
  output logic [NUM_REQ-1:0]   o_rsp_valid,
  output fp4_t                 o_rsp_data,
  output logic [ID_W-1:0]      o_rsp_id,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_issue_cnt,
  output logic                 o_err
);
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  mul_tag_t           tag_q [MUL_LAT];
  mul_tag_t           tag_in, tag_exit;

  // Nothing competes while disabled or held in reset
  assign cand = (i_enable && !i_rst) ? i_req_valid : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i     (cand),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign o_req_ready = gnt;
  assign o_mul_valid = gnt_any;
  assign o_mul_a     = gnt_any ? i_req_a[{gnt_idx, 2'b00} +: 4] : '0;
  assign o_mul_b     = gnt_any ? i_req_b[{gnt_idx, 2'b00} +: 4] : '0;

  // Next pointer sits just past the winner; holds when nothing is granted
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  end

  assign tag_in   = '{valid: gnt_any, id: TAG_ID_W'(gnt_idx)};
  assign tag_exit = tag_q[MUL_LAT-1];

  // Pointer, issue counter and sticky error flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (gnt_any) cnt_q <= cnt_q + CNT_W'(1);
      if (i_mul_valid != tag_exit.valid) err_q <= 1'b1;
    end
  end

  // Tag shift register mirrors the multiplier pipeline depth
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Route a result only when the multiplier and the tag agree it is live
  always_comb begin
    o_rsp_valid = '0;
    o_rsp_data  = '0;
    o_rsp_id    = '0;
    if (i_mul_valid && tag_exit.valid) begin
      o_rsp_valid[tag_exit.id[ID_W-1:0]] = 1'b1;
      o_rsp_data = i_mul_result;
      o_rsp_id   = tag_exit.id[ID_W-1:0];
    end
  end

  // Busy while any stage holds a live tag
  always_comb begin
    o_busy = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) o_busy = o_busy | tag_q[i].valid;
  end

  assign o_issue_cnt = cnt_q;
  assign o_err       = err_q;
endmodule

// File: tb/tb_fp4_mul_arbiter.sv
// Bench for fp4_mul_arbiter: stands in for the multiplier and checks every
// cycle against a queue-based model of grants and returning results.
module tb_fp4_mul_arbiter;
  localparam int N = 4;

  logic           i_clk = 1'b0;
  logic           i_rst, i_enable;
  logic [N-1:0]   i_req_valid;
  logic [4*N-1:0] i_req_a, i_req_b;
  logic [N-1:0]   o_req_ready, o_rsp_valid;
  logic           o_mul_valid, i_mul_valid, o_busy, o_err;
  logic [3:0]     o_mul_a, o_mul_b, i_mul_result, o_rsp_data;
  logic [1:0]     o_rsp_id;
  logic [15:0]    o_issue_cnt;
  logic           force_mv;

  logic [1:0] mv_pipe;
  logic [3:0] mr_pipe [2];

  int ncmp = 0;
  int nfail = 0;

  fp4_mul_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
    .i_req_valid(i_req_valid), .i_req_a(i_req_a), .i_req_b(i_req_b),
    .o_req_ready(o_req_ready), .o_mul_valid(o_mul_valid),
    .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
    .i_mul_result(i_mul_result), .i_mul_valid(i_mul_valid),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_id(o_rsp_id),
    .o_busy(o_busy), .o_issue_cnt(o_issue_cnt), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // E2M1 magnitude table
  function automatic real fp4_mag(input logic [2:0] m);
    case (m)
      3'd0: return 0.0;  3'd1: return 0.5;  3'd2: return 1.0;  3'd3: return 1.5;
      3'd4: return 2.0;  3'd5: return 3.0;  3'd6: return 4.0;  default: return 6.0;
    endcase
  endfunction

  // Exact product rounded to nearest representable, ties to even mantissa
  function automatic logic [3:0] fp4_mul(input logic [3:0] a, input logic [3:0] b);
    real p, d, bd;
    logic [2:0] best;
    p = fp4_mag(a[2:0]) * fp4_mag(b[2:0]);
    best = 3'd0;
    bd = p;
    for (int c = 1; c < 8; c++) begin
      d = p - fp4_mag(3'(c));
      if (d < 0.0) d = -d;
      if (d < bd || (d == bd && (c % 2) == 0 && best[0])) begin
        bd = d;
        best = 3'(c);
      end
    end
    return {a[3] ^ b[3], best};
  endfunction

  // Multiplier stand-in with two-cycle latency, sharing the reset
  always @(posedge i_clk) begin
    if (i_rst) begin
      mv_pipe    <= '0;
      mr_pipe[0] <= '0;
      mr_pipe[1] <= '0;
    end else begin
      mv_pipe    <= {mv_pipe[0], o_mul_valid};
      mr_pipe[0] <= fp4_mul(o_mul_a, o_mul_b);
      mr_pipe[1] <= mr_pipe[0];
    end
  end
  assign i_mul_valid  = mv_pipe[1] | force_mv;
  assign i_mul_result = mr_pipe[1];

  typedef struct {
    int         due;
    int         id;
    logic [3:0] data;
  } exp_t;
  exp_t q[$];
  int m_ptr = 0;
  int m_cnt = 0;
  bit m_err = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: check the DUT against the model, then advance the model
  task automatic step();
    int         gidx;
    bit         found, due_now, mis;
    logic [N-1:0] exp_rv;
    logic [3:0] exp_d;
    int         exp_id;
    @(negedge i_clk);
    if (!i_rst) begin
      found = 0;
      gidx  = 0;
      if (i_enable)
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_ptr + i) % N;
          if (!found && i_req_valid[k]) begin found = 1; gidx = k; end
        end
      due_now = (q.size() > 0) && (q[0].due == cyc);
      exp_rv = '0; exp_d = '0; exp_id = 0;
      if (due_now) begin
        exp_rv[q[0].id] = 1'b1;
        exp_d  = q[0].data;
        exp_id = q[0].id;
      end
      mis = force_mv && !due_now;
      chk("req_ready", 32'(o_req_ready), found ? 32'(1) << gidx : 32'd0);
      chk("mul_valid", 32'(o_mul_valid), 32'(found));
      chk("mul_a", 32'(o_mul_a), found ? 32'(i_req_a[gidx*4 +: 4]) : 32'd0);
      chk("mul_b", 32'(o_mul_b), found ? 32'(i_req_b[gidx*4 +: 4]) : 32'd0);
      chk("rsp_valid", 32'(o_rsp_valid), 32'(exp_rv));
      chk("rsp_data", 32'(o_rsp_data), 32'(exp_d));
      chk("rsp_id", 32'(o_rsp_id), 32'(exp_id));
      chk("busy", 32'(o_busy), 32'(q.size() != 0));
      chk("issue_cnt", 32'(o_issue_cnt), 32'(m_cnt % 65536));
      chk("err", 32'(o_err), 32'(m_err));
      if (due_now) void'(q.pop_front());
      if (found) begin
        q.push_back('{cyc + 2, gidx, fp4_mul(i_req_a[gidx*4 +: 4], i_req_b[gidx*4 +: 4])});
        m_ptr = (gidx + 1) % N;
        m_cnt++;
      end
      if (mis) m_err = 1;
    end else begin
      q.delete();
      m_ptr = 0;
      m_cnt = 0;
      m_err = 0;
    end
    cyc++;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_enable = 1'b0; i_req_valid = '0;
    i_req_a = '0; i_req_b = '0; force_mv = 1'b0;
    step(); step();
    i_rst = 1'b0; i_enable = 1'b1;
    step();

    // Single request from requester 2: 1.5 * 1.5 -> 2.0
    i_req_valid = 4'b0100; i_req_a = 16'h0300; i_req_b = 16'h0300;
    step();
    i_req_valid = '0;
    repeat (3) step();

    // All four valid for 8 cycles
    i_req_valid = 4'b1111; i_req_a = 16'h2222; i_req_b = 16'h2222;
    repeat (8) step();
    i_req_valid = '0;
    repeat (3) step();

    // Move pointer to 3, gap, then 1 and 3 compete
    i_req_valid = 4'b0100;
    step();
    i_req_valid = '0;
    repeat (2) step();
    i_req_valid = 4'b1010; i_req_a = 16'h5a3c; i_req_b = 16'hb4d2;
    repeat (3) step();
    i_req_valid = '0;
    repeat (3) step();

    // Enable dropped mid-stream
    i_req_valid = 4'b1111; i_req_a = 16'h1357; i_req_b = 16'h7531;
    repeat (2) step();
    i_enable = 1'b0;
    repeat (3) step();
    i_enable = 1'b1;
    repeat (2) step();
    i_req_valid = '0;
    repeat (3) step();

    // Spurious multiplier valid with nothing in flight
    force_mv = 1'b1;
    step();
    force_mv = 1'b0;
    repeat (10) step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    step();

    // Reset after two issues; nothing must come back
    i_req_valid = 4'b1111; i_req_a = 16'h6666; i_req_b = 16'h3333;
    repeat (2) step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    repeat (4) step();
    i_req_valid = '0;
    repeat (3) step();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      i_req_valid = 4'($urandom);
      i_enable    = ($urandom_range(0, 7) != 0);
      i_req_a     = 16'($urandom);
      i_req_b     = 16'($urandom);
      step();
    end
    i_req_valid = '0;
    i_enable = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/fp4_mul_arbiter.md
Name: fp4_mul_arbiter

Overview:
- Round-robin arbiter that shares one FP4 multiplier instance between NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle to the multiplier.
- Tracks the requester ID of each operand pair through the multiplier's fixed latency and routes each result back to the requester that issued it.
- Sits between the operand-fetch front ends and the single fp4multiplier datapath instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of requester ID.
- MUL_LAT, 2, cycles from multiplier input valid to multiplier o_valid.
- CNT_W, 16, width of issue counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_enable  in  1  when 0, no new grants; in-flight results still return.
- i_req_valid  in  NUM_REQ  per-requester operand valid.
- i_req_a  in  NUM_REQ*4  packed operand A; requester k uses bits [4k+3:4k].
- i_req_b  in  NUM_REQ*4  packed operand B; same packing as i_req_a.
- o_req_ready  out  NUM_REQ  one-hot grant; a handshake occurs when valid & ready.
- o_mul_valid  out  1  to multiplier i_data_valid.
- o_mul_a  out  4  to multiplier i_a.
- o_mul_b  out  4  to multiplier i_b.
- i_mul_result  in  4  from multiplier o_result.
- i_mul_valid  in  1  from multiplier o_valid.
- o_rsp_valid  out  NUM_REQ  one-hot result strobe; one cycle, no backpressure.
- o_rsp_data  out  4  result, shared by all requesters.
- o_rsp_id  out  ID_W  requester ID of the current result.
- o_busy  out  1  1 when any tag is in flight.
- o_issue_cnt  out  CNT_W  number of pairs issued; wraps.
- o_err  out  1  sticky tag/valid mismatch flag.

Behaviour:
- Reset values: all outputs 0; RR pointer = 0 (requester 0 has top priority); tag pipeline cleared; o_err = 0.
- Arbitration (combinational within the cycle):
  - Candidates = i_req_valid when i_enable = 1, otherwise none.
  - Search starts at the pointer and wraps modulo NUM_REQ; o_req_ready is one-hot on the first candidate found.
  - o_req_ready never asserts for a requester whose valid is low.
  - Requesters must not make valid depend on ready.
- Issue: on a grant to k, o_mul_valid = 1 and o_mul_a/o_mul_b = operands of k, combinationally in the same cycle. With no grant, o_mul_valid = 0 and o_mul_a/o_mul_b = 0.
- Pointer update: after a grant to k, the pointer becomes (k+1) mod NUM_REQ at the next edge. With no grant, the pointer holds.
- Tag pipeline:
  - MUL_LAT-deep shift register of {valid, id}; stage 0 loads {grant_any, granted_id} every cycle.
  - The tag leaving the last stage aligns with i_mul_valid for that transaction, MUL_LAT cycles after issue.
- Response:
  - When i_mul_valid = 1 and the exiting tag is valid: o_rsp_valid[id] = 1, o_rsp_data = i_mul_result, o_rsp_id = id. These are combinational from the aligned inputs, so total request-to-response latency is MUL_LAT cycles.
  - Otherwise o_rsp_valid = 0, and o_rsp_data and o_rsp_id hold 0.
- Error: o_err sets at the next edge whenever i_mul_valid differs from the exiting tag valid. It stays set until reset. A mismatched result is dropped; no o_rsp_valid is generated for it.
- o_busy = OR of all tag-stage valids.
- o_issue_cnt increments by 1 per grant and wraps from 2^CNT_W−1 to 0.
- Throughput: one issue per cycle sustained; with all requesters valid, the grant order is 0,1,2,3,0,...
- i_enable drop mid-stream: grants stop the same cycle; the pointer holds; in-flight tags still complete.
- Reset mid-operation: the tag pipeline is cleared, so in-flight results are discarded. The multiplier shares i_rst, so no stale i_mul_valid arrives.
- Single requester: it is granted every cycle it is valid.

Decomposition:
- Package fp4_pkg holds:
  - typedef fp4_t (logic [3:0]) with field constants: sign bit 3, exponent [2:1], mantissa bit 0.
  - typedef mul_tag_t {valid, id}.
  - Default MUL_LAT constant = 2.
- Sub-module rr_arbiter (parameterised NUM_REQ): request vector and pointer in, one-hot grant and grant index out. Reused by later MAC schedulers.

Test Plan:
- Single request, using a reference multiplier model: requester 2 sends a=4'b0011, b=4'b0011 at cycle 0 → o_req_ready=4'b0100 in cycle 0; o_rsp_valid=4'b0100, o_rsp_data=4'b0100, o_rsp_id=2 at cycle 2; o_issue_cnt=1.
- All four requesters valid for 8 cycles (a=4'b0010, b=4'b0010) → grants 0,1,2,3,0,1,2,3; responses in the same order, each with data 4'b0010, 2 cycles after its grant; o_busy=1 throughout.
- Fairness after a gap: pointer at 3, requesters 1 and 3 valid → grant 3, then 1, then 3.
- i_enable=0 for 3 cycles with all requesters valid → no o_req_ready and o_mul_valid=0 during those cycles; the 2 in-flight responses still arrive; the pointer is unchanged on re-enable.
- Fault injection: force i_mul_valid=1 with the tag pipeline empty → o_err=1 on the next cycle and no o_rsp_valid; o_err still 1 after 10 idle cycles; cleared by reset.
- Reset mid-stream: assert i_rst 1 cycle after two issues → no responses after reset; o_busy=0; o_issue_cnt=0; next grant goes to requester 0.
